// File: rtl/arm7_mem_pkg.sv
// Shared types and constants for the arm7_cpu memory-side responder.
// Holds the access FSM state encoding, default bus widths and the out-of-range read value.
package arm7_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DATA_W = 32;

   // Returned for reads whose word index lies beyond the implemented RAM.
   localparam logic [31:0] OOR_RDATA = 32'h0;

endpackage

// File: rtl/arm7_sram_sp.sv
// Single-port synchronous RAM, DEPTH x WIDTH, one-cycle registered read.
// A write cycle leaves the read register unchanged.
module arm7_sram_sp #(
   parameter int DEPTH = 4096,
   parameter int WIDTH = 32,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_array [DEPTH];
   logic [WIDTH-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_array[addr] <= wdata;
         end else begin
            rdata_reg <= mem_array[addr];
         end
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/arm7_mem_responder.sv
// Memory-side responder for the arm7_cpu memory port: one word access at a time,
// WAIT_CYCLES wait states, then a one-cycle mem_ready (with mem_err on bad requests).
module arm7_mem_responder
   import arm7_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_re,
   input  logic              mem_we,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_err
);

   localparam int IDX_W  = ADDR_W - 2;
   localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("arm7_mem_responder: WAIT_CYCLES must lie in 0..15");
   end

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg;
   logic [RAM_AW-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                wr_reg;
   logic                err_reg;
   logic                oor_reg;
   logic                ready_reg;
   logic                err_out_reg;
   logic [DATA_W-1:0]   rdata_reg;

   logic [IDX_W-1:0]    req_idx;
   logic                req_valid;
   logic                req_oor;
   logic                req_err;
   logic                issue;
   logic                ram_en;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_q;
   logic [DATA_W-1:0]   rd_value;

   // Request decode, only consulted while IDLE.
   assign req_idx   = mem_addr[ADDR_W-1:2];
   assign req_valid = mem_re | mem_we;
   assign req_oor   = 64'(req_idx) >= 64'(DEPTH_WORDS);
   assign req_err   = (mem_re & mem_we) | (|mem_addr[1:0]) | req_oor;

   // The RAM is touched only on the BUSY->RESP edge; holding off while rst is
   // high keeps an aborted write from landing in memory.
   assign issue  = (state_reg == BUSY) && (cnt_reg == 4'd0);
   assign ram_en = issue && !rst;
   assign ram_we = ram_en && wr_reg && !oor_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = BUSY;
         BUSY:    if (cnt_reg == 4'd0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= 4'd0;
         ready_reg   <= 1'b0;
         err_out_reg <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         ready_reg   <= issue;
         err_out_reg <= issue && err_reg;
         if (state_reg == IDLE && req_valid) begin
            cnt_reg <= 4'(WAIT_CYCLES);
         end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
         end
         if (state_reg == RESP && !wr_reg) begin
            rdata_reg <= rd_value;
         end
      end
   end

   // Request latch: inputs are only looked at while IDLE.
   always_ff @(posedge clk) begin
      if (state_reg == IDLE && req_valid) begin
         addr_reg  <= req_idx[RAM_AW-1:0];
         wdata_reg <= mem_wdata;
         wr_reg    <= mem_we;
         err_reg   <= req_err;
         oor_reg   <= req_oor;
      end
   end

   arm7_sram_sp #(
      .DEPTH (DEPTH_WORDS),
      .WIDTH (DATA_W),
      .AW    (RAM_AW)
   ) u_sram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (addr_reg),
      .wdata (wdata_reg),
      .rdata (ram_q)
   );

   assign rd_value = oor_reg ? DATA_W'(OOR_RDATA) : ram_q;

   // During a read RESP the RAM register drives the bus directly; otherwise the last read value is held.
   assign mem_rdata = (state_reg == RESP && !wr_reg) ? rd_value : rdata_reg;
   assign mem_ready = ready_reg;
   assign mem_err   = err_out_reg;

endmodule

// File: tb/tb_arm7_mem_responder.sv
// Self-checking bench for arm7_mem_responder: directed vector table, reset/hold corner
// sequences, a WAIT_CYCLES=0 instance, and randomized traffic against a word-array model.
module tb_arm7_mem_responder;

   localparam int DEPTH = 4096;
   localparam int WAIT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_re, a_we, b_re, b_we;
   logic [31:0] a_rdata, b_rdata;
   logic        a_ready, a_err, b_ready, b_err;

   always #5 clk = ~clk;

   arm7_mem_responder #(
      .ADDR_W(20), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)
   ) u_dut_a (
      .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_re(a_re), .mem_we(a_we), .mem_rdata(a_rdata),
      .mem_ready(a_ready), .mem_err(a_err)
   );

   arm7_mem_responder #(
      .ADDR_W(20), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_re(b_re), .mem_we(b_we), .mem_rdata(b_rdata),
      .mem_ready(b_ready), .mem_err(b_err)
   );

   int tests_run = 0;
   int fails     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Behavioural model: a sparse word array plus the last value returned by a read.
   logic [31:0] model_mem [int];
   logic [31:0] model_rdata;

   function automatic void model_apply(input logic [19:0] addr, input logic [31:0] wdata,
                                       input logic re, input logic we,
                                       output logic [31:0] exp_rdata, output logic exp_err);
      int  idx;
      bit  oor;
      idx = int'(addr) / 4;
      oor = idx >= DEPTH;
      exp_err = (re && we) || (addr % 4 != 0) || oor;
      if (we) begin
         if (!oor) model_mem[idx] = wdata;
      end else begin
         if (oor) model_rdata = 32'h0;
         else if (model_mem.exists(idx)) model_rdata = model_mem[idx];
         else model_rdata = 32'hx;
      end
      exp_rdata = model_rdata;
   endfunction

   // Called at a negedge; returns at a negedge with the request withdrawn.
   task automatic access_a(input logic [19:0] addr, input logic [31:0] wdata,
                           input logic re, input logic we,
                           output logic [31:0] rdata, output logic err, output int lat);
      a_addr = addr; a_wdata = wdata; a_re = re; a_we = we;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (a_ready) break;
      end
      if (!a_ready) begin
         tests_run++; fails++;
         $display("FAIL ready_timeout: no mem_ready within 40 cycles, addr %05h", addr);
         lat = -1;
      end
      rdata = a_rdata; err = a_err;
      a_re = 1'b0; a_we = 1'b0;
      $display("[TB] txn addr=%05h re=%0d we=%0d wdata=%08h rdata=%08h err=%0d lat=%0d",
               addr, re, we, wdata, rdata, err, lat);
      @(posedge clk); @(negedge clk);
      chk("ready_one_cycle", 32'(a_ready), 32'h0);
   endtask

   // Access checked against the model.
   task automatic model_access(input string name, input logic [19:0] addr, input logic [31:0] wdata,
                               input logic re, input logic we);
      logic [31:0] got_rdata, exp_rdata;
      logic        got_err, exp_err;
      int          lat;
      model_apply(addr, wdata, re, we, exp_rdata, exp_err);
      access_a(addr, wdata, re, we, got_rdata, got_err, lat);
      chk({name, "_rdata"}, got_rdata, exp_rdata);
      chk({name, "_err"}, 32'(got_err), 32'(exp_err));
      chk({name, "_lat"}, 32'(lat), 32'(2 + WAIT));
   endtask

   typedef struct {
      string       name;
      logic [19:0] addr;
      logic [31:0] wdata;
      logic        re;
      logic        we;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] got_rdata, exp_rdata;
      logic        got_err, exp_err;
      int          lat;
      int          bad_ready;
      int          b_ready_at[$];

      vecs[0]  = '{"wr_cafe",   20'h00010, 32'hCAFEBABE, 1'b0, 1'b1, 32'h00000000, 1'b0};
      vecs[1]  = '{"rd_cafe",   20'h00010, 32'h0,        1'b1, 1'b0, 32'hCAFEBABE, 1'b0};
      vecs[2]  = '{"wr_word0",  20'h00000, 32'h11110000, 1'b0, 1'b1, 32'hCAFEBABE, 1'b0};
      vecs[3]  = '{"wr_both",   20'h00020, 32'h12345678, 1'b1, 1'b1, 32'hCAFEBABE, 1'b1};
      vecs[4]  = '{"rd_20",     20'h00020, 32'h0,        1'b1, 1'b0, 32'h12345678, 1'b0};
      vecs[5]  = '{"rd_misal",  20'h00013, 32'h0,        1'b1, 1'b0, 32'hCAFEBABE, 1'b1};
      vecs[6]  = '{"wr_oor",    20'h04000, 32'hDEADBEEF, 1'b0, 1'b1, 32'hCAFEBABE, 1'b1};
      vecs[7]  = '{"rd_oor",    20'h04000, 32'h0,        1'b1, 1'b0, 32'h00000000, 1'b1};
      vecs[8]  = '{"rd_word0",  20'h00000, 32'h0,        1'b1, 1'b0, 32'h11110000, 1'b0};
      vecs[9]  = '{"wr_misal",  20'h00046, 32'h11112222, 1'b0, 1'b1, 32'h11110000, 1'b1};
      vecs[10] = '{"rd_44",     20'h00044, 32'h0,        1'b1, 1'b0, 32'h11112222, 1'b0};

      rst = 1'b1;
      a_addr = '0; a_wdata = '0; a_re = 1'b0; a_we = 1'b0;
      b_addr = '0; b_wdata = '0; b_re = 1'b0; b_we = 1'b0;
      model_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 32'(a_ready), 32'h0);
      chk("reset_err",   32'(a_err),   32'h0);
      chk("reset_rdata", a_rdata,      32'h0);
      chk("reset_b_ready", 32'(b_ready), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 11; i++) begin
         model_apply(vecs[i].addr, vecs[i].wdata, vecs[i].re, vecs[i].we, exp_rdata, exp_err);
         access_a(vecs[i].addr, vecs[i].wdata, vecs[i].re, vecs[i].we, got_rdata, got_err, lat);
         chk({vecs[i].name, "_rdata"}, got_rdata, vecs[i].exp_rdata);
         chk({vecs[i].name, "_err"}, 32'(got_err), 32'(vecs[i].exp_err));
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'(2 + WAIT));
      end

      // Reset during BUSY just before the write would commit.
      model_access("wr_40_prior", 20'h00040, 32'h0BADF00D, 1'b0, 1'b1);
      a_addr = 20'h00040; a_wdata = 32'hAAAA5555; a_we = 1'b1;
      bad_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (a_ready) bad_ready++;
      end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      if (a_ready) bad_ready++;
      chk("abort_rdata_reset", a_rdata, 32'h0);
      model_rdata = 32'h0;
      rst = 1'b0; a_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         if (a_ready) bad_ready++;
      end
      chk("abort_no_ready", 32'(bad_ready), 32'h0);
      $display("[TB] txn reset abort of write 40=AAAA5555, spurious ready count=%0d", bad_ready);
      model_access("rd_40_after_abort", 20'h00040, 32'h0, 1'b1, 1'b0);

      // Inputs changed while BUSY must not affect the latched access.
      model_access("wr_54_prior", 20'h00054, 32'h55AA55AA, 1'b0, 1'b1);
      a_addr = 20'h00050; a_wdata = 32'h5A5A5A5A; a_we = 1'b1;
      @(posedge clk); @(negedge clk);
      a_addr = 20'h00057; a_wdata = 32'hFFFF0000; a_re = 1'b1;
      lat = 1;
      while (!a_ready && lat < 40) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      chk("hold_ready_lat", 32'(lat), 32'(2 + WAIT));
      chk("hold_err", 32'(a_err), 32'h0);
      $display("[TB] txn write 50=5A5A5A5A with inputs changed in BUSY, lat=%0d err=%0d", lat, a_err);
      a_re = 1'b0; a_we = 1'b0;
      model_apply(20'h00050, 32'h5A5A5A5A, 1'b0, 1'b1, exp_rdata, exp_err);
      @(posedge clk); @(negedge clk);
      model_access("rd_50_hold", 20'h00050, 32'h0, 1'b1, 1'b0);
      model_access("rd_54_hold", 20'h00054, 32'h0, 1'b1, 1'b0);

      // WAIT_CYCLES=0 instance: held read request gives readies 3 cycles apart.
      b_addr = 20'h00008; b_re = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); @(negedge clk);
         if (b_ready) b_ready_at.push_back(n);
      end
      b_re = 1'b0;
      chk("b_ready_count", 32'(b_ready_at.size()), 32'd4);
      if (b_ready_at.size() >= 2) begin
         chk("b_first_lat", 32'(b_ready_at[0]), 32'd2);
         chk("b_period",    32'(b_ready_at[1] - b_ready_at[0]), 32'd3);
         $display("[TB] txn wait0 held read: ready at cycles %0d and %0d", b_ready_at[0], b_ready_at[1]);
      end
      chk("b_err", 32'(b_err), 32'h0);

      // Randomized traffic over a small pool of words plus out-of-range indices.
      for (int i = 0; i < 8; i++)
         model_access("pool_init", 20'((32'h100 + i) * 4), $urandom, 1'b0, 1'b1);
      for (int t = 0; t < 150; t++) begin
         logic [19:0] addr;
         int          op;
         int          idx;
         if ($urandom_range(0, 9) == 0) idx = DEPTH + int'($urandom_range(0, 300));
         else idx = 32'h100 + int'($urandom_range(0, 7));
         addr = 20'(idx * 4);
         if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         op = int'($urandom_range(0, 4));
         model_access("rand", addr, $urandom,
                      (op != 1 && op != 3) ? 1'b1 : 1'b0, (op == 1 || op == 3 || op == 4) ? 1'b1 : 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
